// File: rtl/key_expansion.sv
`timescale 1ns/1ps
// key_expansion: iterative AES-128 key schedule producing round keys 0..10 on a
// valid/ready stream. One S-box lookup per cycle; 4 SUB cycles plus 1 MIX cycle per round.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start, key_in  - expansion request and cipher key (sampled in IDLE only)
//   round_key      - current round key {w0,w1,w2,w3}, byte 0 in bits [127:120]
//   round_idx      - index of round_key (0..10)
//   rk_valid/ready - output handshake
//   busy, done     - expansion in progress / one-cycle completion pulse
module key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 2;

    // Forward AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EMIT, SUB, MIX} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   w0_q, w1_q, w2_q, w3_q;
    logic [WORD_W-1:0]   w0_d, w1_d, w2_d, w3_d;
    logic [WORD_W-1:0]   temp_q, temp_d;
    logic [CNT_W-1:0]    sub_cnt_q, sub_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                rk_valid_q, busy_q, done_q, done_d;
    logic [7:0]          sbox_in_c, sbox_out_c;

    // Rcon for the round being produced (idx 0 -> round 1).
    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // RotWord byte select: sub_cnt k reads byte (k+1) mod 4 of w3.
    always_comb begin
        sbox_in_c = w3_q[31:24];
        case (sub_cnt_q)
            2'd0:    sbox_in_c = w3_q[23:16];
            2'd1:    sbox_in_c = w3_q[15:8];
            2'd2:    sbox_in_c = w3_q[7:0];
            default: sbox_in_c = w3_q[31:24];
        endcase
    end

    // Entry i lives at bits [8*(255-i) +: 8], and 255-i is just ~i.
    assign sbox_out_c = SBOX_TBL[{~sbox_in_c, 3'b000} +: 8];

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        w0_d      = w0_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        w3_d      = w3_q;
        temp_d    = temp_q;
        sub_cnt_d = sub_cnt_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w0_d    = key_in[127:96];
                    w1_d    = key_in[95:64];
                    w2_d    = key_in[63:32];
                    w3_d    = key_in[31:0];
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_q == 4'd10) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sub_cnt_d = '0;
                        state_d   = SUB;
                    end
                end
            end
            SUB: begin
                case (sub_cnt_q)
                    2'd0:    temp_d[31:24] = sbox_out_c;
                    2'd1:    temp_d[23:16] = sbox_out_c;
                    2'd2:    temp_d[15:8]  = sbox_out_c;
                    default: temp_d[7:0]   = sbox_out_c;
                endcase
                sub_cnt_d = CNT_W'(sub_cnt_q + CNT_W'(1));
                if (sub_cnt_q == 2'd3) begin
                    state_d = MIX;
                end
            end
            MIX: begin
                w0_d    = w0_q ^ temp_q ^ {rcon(idx_q), 24'h000000};
                w1_d    = w1_q ^ w0_d;
                w2_d    = w2_q ^ w1_d;
                w3_d    = w3_q ^ w2_d;
                idx_d   = IDX_W'(idx_q + IDX_W'(1));
                state_d = EMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            w0_q       <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            w3_q       <= '0;
            temp_q     <= '0;
            sub_cnt_q  <= '0;
            idx_q      <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            w3_q       <= w3_d;
            temp_q     <= temp_d;
            sub_cnt_q  <= sub_cnt_d;
            idx_q      <= idx_d;
            rk_valid_q <= (state_d == EMIT);
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
        end
    end

    assign round_key = {w0_q, w1_q, w2_q, w3_q};
    assign round_idx = idx_q;
    assign rk_valid  = rk_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_expansion.sv
`timescale 1ns/1ps
// Scoreboard bench for key_expansion: stimulus pushes expected round keys,
// a negedge monitor pops and compares on every rk_valid && rk_ready transfer.
module tb_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    bit rand_en = 1'b0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;

    exp_t sb[$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    key_expansion dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Single driver of rk_ready: random when enabled, otherwise held high.
    always @(posedge clk) begin
        #1;
        rk_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard pop on transfer, hold check across stalls.
    bit           stall_q = 1'b0;
    logic [127:0] held_key;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", 128'(rk_valid), 128'(1));
                chk("stall_hold", round_key, held_key);
            end
            if (rk_valid && rk_ready) begin
                xfers++;
                stall_q = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transfer actual idx=%0d required no transfer", round_idx);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rk_idx_%0d", e.idx), 128'(round_idx), 128'(e.idx));
                    if (e.chk_key)
                        chk($sformatf("rk_key_%0d", e.idx), round_key, e.key);
                end
            end else if (rk_valid) begin
                stall_q  = 1'b1;
                held_key = round_key;
            end else begin
                stall_q = 1'b0;
            end
        end
    end

    task automatic push_fips(input int last);
        for (int i = 0; i <= last; i++)
            sb.push_back('{idx: 4'(i), key: fips_rk[i], chk_key: 1'b1});
    endtask

    // All-zero key: rounds 0, 1, 2 and 10 are checked by value, the rest by index.
    task automatic push_zero();
        logic [127:0] k;
        bit           c;
        for (int i = 0; i <= 10; i++) begin
            c = 1'b1;
            case (i)
                0:       k = 128'h0;
                1:       k = 128'h62636363626363636263636362636363;
                2:       k = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
                10:      k = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
                default: begin k = 128'h0; c = 1'b0; end
            endcase
            sb.push_back('{idx: 4'(i), key: k, chk_key: c});
        end
    endtask

    // Issue a one-cycle start; returns at T+1 (#1 after the accepting edge).
    task automatic do_start(input logic [127:0] k);
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done required=done within %0d cycles", bound);
        end
    endtask

    initial begin
        int n;
        int bad;
        int x0;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_round_key", round_key, 128'h0);
        chk("rst_round_idx", 128'(round_idx), 128'(0));
        chk("rst_outputs", 128'({rk_valid, busy, done}), 128'(0));
        rst = 1'b0;

        // Idle with start low.
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (rk_valid || busy || done) bad++;
        end
        chk("idle_quiet", 128'(bad), 128'(0));

        // FIPS-197 key, no stalls, exact latency.
        push_fips(10);
        do_start(FIPS_KEY);
        chk("fips_r0_valid", 128'(rk_valid), 128'(1));
        chk("fips_r0_busy", 128'(busy), 128'(1));
        chk("fips_r0_key", round_key, FIPS_KEY);
        repeat (6) begin @(posedge clk); #1; end
        chk("fips_r1_at_t7", {124'(rk_valid), round_idx}, {124'(1), 4'd1});
        wait_done(200, n);
        chk("fips_done_latency", 128'(n), 128'(55));
        chk("fips_busy_at_done", 128'(busy), 128'(0));
        chk("fips_sb_empty", 128'(sb.size()), 128'(0));

        // Start in the done cycle: all-zero key.
        push_zero();
        start  = 1'b1;
        key_in = 128'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_start_valid", 128'(rk_valid), 128'(1));
        chk("done_start_idx", 128'(round_idx), 128'(0));
        chk("done_pulse_width", 128'(done), 128'(0));

        // Start with another key mid-expansion must be ignored.
        repeat (20) begin @(posedge clk); #1; end
        start  = 1'b1;
        key_in = ALT_KEY;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200, n);
        chk("zero_done_latency", 128'(n), 128'(40));
        chk("zero_sb_empty", 128'(sb.size()), 128'(0));

        // Random backpressure.
        @(posedge clk);
        #1;
        rand_en = 1'b1;
        x0 = xfers;
        push_fips(10);
        do_start(FIPS_KEY);
        wait_done(3000, n);
        rand_en = 1'b0;
        chk("bp_sb_empty", 128'(sb.size()), 128'(0));
        chk("bp_transfers", 128'(xfers - x0), 128'(11));
        repeat (2) begin @(posedge clk); #1; end

        // Reset during SUB of round 4 (after round 4 is emitted).
        push_fips(4);
        do_start(FIPS_KEY);
        n = 0;
        while (!(rk_valid && round_idx == 4'd4) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_round4", 128'(n), 128'(24));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_round_key", round_key, 128'h0);
        chk("midrst_idx", 128'(round_idx), 128'(0));
        chk("midrst_outputs", 128'({rk_valid, busy, done}), 128'(0));
        chk("midrst_sb_empty", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_fips(10);
        do_start(FIPS_KEY);
        chk("post_rst_r0", round_key, FIPS_KEY);
        wait_done(200, n);
        chk("post_rst_latency", 128'(n), 128'(61));
        chk("post_rst_sb_empty", 128'(sb.size()), 128'(0));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
